// File: rtl/lif_neuron_update_scheduler.sv
// rtl/lif_neuron_update_scheduler.sv - time-multiplexes one LIF neuron unit across a RAM of neuron states
//
// Purpose: on each Start pulse, sweeps neuron addresses 0..count-1. Per neuron it reads the
// status RAMs, enables the shared unit for UNIT_LATENCY cycles, writes the results back and,
// if the unit spiked, hands the neuron address to the spike router with a valid/ready handshake.
//
// Ports:
//   Clock, Reset            rising-edge clock, asynchronous active-low reset
//   Start, NeuronCount      sweep request and neuron count (count sampled with Start, clamped to NEURON_NUM)
//   Busy, Done, Timestep    sweep in progress, one-cycle completion pulse, completed-sweep counter
//   RdEn, RdAddr            neuron RAM read request (data valid the following cycle)
//   UpdateEnable            enable for the shared neuron unit
//   WrEn, WrAddr            write-back of Vmem/gex/gin/RefVal
//   SpikeIn                 unit spike output, sampled during write-back
//   SpikeValid, SpikeAddr,
//   SpikeReady              spike address handshake towards the router
//   SpikeCount              (only with SCHED_SPIKE_COUNT_EN) spikes accepted in the current/last sweep
//
// Optional feature macro: SCHED_SPIKE_COUNT_EN
module lif_neuron_update_scheduler #(
    parameter int NEURON_NUM        = 256,
    parameter int NEURON_ADDR_WIDTH = 8,
    parameter int UNIT_LATENCY      = 1,
    parameter int TSTEP_WIDTH       = 16
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic [NEURON_ADDR_WIDTH:0]   NeuronCount,
    output logic                         Busy,
    output logic                         Done,
    output logic [TSTEP_WIDTH-1:0]       Timestep,
    output logic                         RdEn,
    output logic [NEURON_ADDR_WIDTH-1:0] RdAddr,
    output logic                         UpdateEnable,
    output logic                         WrEn,
    output logic [NEURON_ADDR_WIDTH-1:0] WrAddr,
    input  logic                         SpikeIn,
    output logic                         SpikeValid,
    output logic [NEURON_ADDR_WIDTH-1:0] SpikeAddr,
    input  logic                         SpikeReady
`ifdef SCHED_SPIKE_COUNT_EN
    ,
    output logic [NEURON_ADDR_WIDTH:0]   SpikeCount
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_UPDATE,
        S_WRITE,
        S_SPIKE,
        S_DONE
    } state_t;

    localparam logic [NEURON_ADDR_WIDTH:0]   NUM_MAX  = (NEURON_ADDR_WIDTH+1)'(NEURON_NUM);
    localparam logic [NEURON_ADDR_WIDTH:0]   CNT_ONE  = (NEURON_ADDR_WIDTH+1)'(1);
    localparam logic [NEURON_ADDR_WIDTH-1:0] IDX_ONE  = NEURON_ADDR_WIDTH'(1);
    localparam logic [TSTEP_WIDTH-1:0]       TS_ONE   = TSTEP_WIDTH'(1);
    // Counter runs LAT_INIT..0, so UPDATE lasts exactly UNIT_LATENCY cycles.
    localparam logic [3:0]                   LAT_INIT = 4'(UNIT_LATENCY - 1);

    state_t                         state_q, state_d;
    logic [NEURON_ADDR_WIDTH-1:0]   index_q, index_d;
    logic [NEURON_ADDR_WIDTH:0]     count_q, count_d;
    logic [3:0]                     lat_q, lat_d;
    logic [TSTEP_WIDTH-1:0]         ts_q, ts_d;
    logic [NEURON_ADDR_WIDTH:0]     start_count;
    logic                           is_last;
`ifdef SCHED_SPIKE_COUNT_EN
    logic [NEURON_ADDR_WIDTH:0]     spk_cnt_q, spk_cnt_d;
`endif

    assign start_count = (NeuronCount > NUM_MAX) ? NUM_MAX : NeuronCount;
    // Compare index+1 against count so the last address (NEURON_NUM-1) never needs to wrap.
    assign is_last     = (({1'b0, index_q} + CNT_ONE) == count_q);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            count_q   <= '0;
            lat_q     <= '0;
            ts_q      <= '0;
`ifdef SCHED_SPIKE_COUNT_EN
            spk_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            count_q   <= count_d;
            lat_q     <= lat_d;
            ts_q      <= ts_d;
`ifdef SCHED_SPIKE_COUNT_EN
            spk_cnt_q <= spk_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        count_d   = count_q;
        lat_d     = lat_q;
        ts_d      = ts_q;
`ifdef SCHED_SPIKE_COUNT_EN
        spk_cnt_d = spk_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    count_d   = start_count;
                    index_d   = '0;
`ifdef SCHED_SPIKE_COUNT_EN
                    spk_cnt_d = '0;
`endif
                    state_d   = (start_count == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                lat_d   = LAT_INIT;
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                if (lat_q == 4'd0) begin
                    state_d = S_WRITE;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_WRITE: begin
                if (SpikeIn) begin
                    state_d = S_SPIKE;
                end else if (is_last) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + IDX_ONE;
                    state_d = S_READ;
                end
            end
            S_SPIKE: begin
                if (SpikeReady) begin
`ifdef SCHED_SPIKE_COUNT_EN
                    spk_cnt_d = spk_cnt_q + CNT_ONE;
`endif
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + IDX_ONE;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                ts_d    = ts_q + TS_ONE;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs; addresses are forced to zero outside their strobe.
    assign Busy         = (state_q != S_IDLE);
    assign Done         = (state_q == S_DONE);
    assign Timestep     = ts_q;
    assign RdEn         = (state_q == S_READ);
    assign RdAddr       = RdEn ? index_q : '0;
    assign UpdateEnable = (state_q == S_UPDATE);
    assign WrEn         = (state_q == S_WRITE);
    assign WrAddr       = WrEn ? index_q : '0;
    assign SpikeValid   = (state_q == S_SPIKE);
    assign SpikeAddr    = SpikeValid ? index_q : '0;
`ifdef SCHED_SPIKE_COUNT_EN
    assign SpikeCount   = spk_cnt_q;
`endif

endmodule

// File: tb/tb_lif_neuron_update_scheduler.sv
// tb/tb_lif_neuron_update_scheduler.sv - self-checking bench for lif_neuron_update_scheduler
module tb_lif_neuron_update_scheduler;

    localparam int NN = 256;
    localparam int AW = 8;
    localparam int L  = 2;
    localparam int TW = 8;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          Start = 1'b0;
    logic [AW:0]   NeuronCount = '0;
    logic          Busy, Done, RdEn, UpdateEnable, WrEn, SpikeValid;
    logic [TW-1:0] Timestep;
    logic [AW-1:0] RdAddr, WrAddr, SpikeAddr;
    logic          SpikeIn = 1'b0;
    logic          SpikeReady = 1'b0;
`ifdef SCHED_SPIKE_COUNT_EN
    logic [AW:0]   SpikeCount;
`endif

    lif_neuron_update_scheduler #(
        .NEURON_NUM(NN), .NEURON_ADDR_WIDTH(AW), .UNIT_LATENCY(L), .TSTEP_WIDTH(TW)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .NeuronCount(NeuronCount),
        .Busy(Busy), .Done(Done), .Timestep(Timestep),
        .RdEn(RdEn), .RdAddr(RdAddr), .UpdateEnable(UpdateEnable),
        .WrEn(WrEn), .WrAddr(WrAddr), .SpikeIn(SpikeIn),
        .SpikeValid(SpikeValid), .SpikeAddr(SpikeAddr), .SpikeReady(SpikeReady)
`ifdef SCHED_SPIKE_COUNT_EN
        , .SpikeCount(SpikeCount)
`endif
    );

    always #5 Clock = ~Clock;

    // One entry per clock cycle after the Start edge: what the outputs must show and
    // what the bench drives on SpikeIn / SpikeReady during that cycle.
    typedef struct {
        bit busy, done, rd, upd, wr, sv, sin, rdy;
        int addr;
    } cyc_t;

    cyc_t          sched[$];
    bit            sp[NN];
    int            dl[NN];
    int            vectors = 0;
    int            miscompares = 0;
    logic [TW-1:0] exp_ts = '0;
    int            exp_sc = 0;

    function automatic cyc_t cyc(bit busy, bit done, bit rd, bit upd, bit wr, bit sv, int addr);
        cyc_t c;
        c.busy = busy; c.done = done; c.rd = rd; c.upd = upd; c.wr = wr; c.sv = sv;
        c.sin = 1'b0; c.rdy = 1'b0; c.addr = addr;
        return c;
    endfunction

    // Expected cycle sequence for a sweep, straight from the per-neuron step list.
    task automatic build(input int count);
        int   n;
        cyc_t c;
        n = (count > NN) ? NN : count;
        sched.delete();
        exp_sc = 0;
        for (int i = 0; i < n; i++) begin
            sched.push_back(cyc(1, 0, 1, 0, 0, 0, i));
            for (int u = 0; u < L; u++) sched.push_back(cyc(1, 0, 0, 1, 0, 0, i));
            c = cyc(1, 0, 0, 0, 1, 0, i);
            c.sin = sp[i];
            sched.push_back(c);
            if (sp[i]) begin
                exp_sc++;
                for (int d = 0; d < dl[i]; d++) sched.push_back(cyc(1, 0, 0, 0, 0, 1, i));
                c = cyc(1, 0, 0, 0, 0, 1, i);
                c.rdy = 1'b1;
                sched.push_back(c);
            end
        end
        sched.push_back(cyc(1, 1, 0, 0, 0, 0, 0));
        sched.push_back(cyc(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic check_cycle(input int k, input cyc_t e);
        logic [5:0]    got_f, exp_f;
        logic [AW-1:0] got_a, exp_a;
        got_f = {Busy, Done, RdEn, UpdateEnable, WrEn, SpikeValid};
        exp_f = {e.busy, e.done, e.rd, e.upd, e.wr, e.sv};
        got_a = RdEn ? RdAddr : (WrEn ? WrAddr : (SpikeValid ? SpikeAddr : '0));
        exp_a = (e.rd || e.wr || e.sv) ? AW'(e.addr) : '0;
        vectors++;
        assert ({got_f, got_a} === {exp_f, exp_a}) else begin
            miscompares++;
            $error("FAIL cycle%0d flags/addr observed=%b/%0d expected=%b/%0d", k, got_f, got_a, exp_f, exp_a);
        end
    endtask

    task automatic check_zero(input string tag);
        logic [6*1+3*AW+TW-1:0] got;
        got = {Busy, Done, RdEn, UpdateEnable, WrEn, SpikeValid, RdAddr, WrAddr, SpikeAddr, Timestep};
        vectors++;
        assert (got === '0) else begin
            miscompares++;
            $error("FAIL %s outputs observed=%h expected=0", tag, got);
        end
`ifdef SCHED_SPIKE_COUNT_EN
        vectors++;
        assert (SpikeCount === '0) else begin
            miscompares++;
            $error("FAIL %s spike_count observed=%0d expected=0", tag, SpikeCount);
        end
`endif
    endtask

    // restart_at: cycle at which Start is pulsed again while busy (0 = never).
    // abort_at: cycle at which Reset is asserted mid-sweep (0 = never).
    task automatic run_sweep(input int count, input int restart_at, input int abort_at);
        build(count);
        @(negedge Clock);
        Start = 1'b1;
        NeuronCount = (AW+1)'(count);
        for (int k = 1; k <= sched.size(); k++) begin
            @(negedge Clock);
            if (k == 1) Start = 1'b0;
            if (k == restart_at) begin
                Start = 1'b1;
                NeuronCount = (AW+1)'(1);
            end
            if (k == restart_at + 1) Start = 1'b0;
            if (k == abort_at) begin
                Reset = 1'b0;
                SpikeIn = 1'b0;
                SpikeReady = 1'b0;
                #1;
                check_zero("mid_sweep_reset");
                exp_ts = '0;
                @(negedge Clock);
                Reset = 1'b1;
                return;
            end
            check_cycle(k, sched[k-1]);
            SpikeIn = sched[k-1].sin;
            SpikeReady = sched[k-1].rdy;
            if (k == sched.size()) begin
                exp_ts = exp_ts + 1'b1;
                vectors++;
                assert (Timestep === exp_ts) else begin
                    miscompares++;
                    $error("FAIL timestep observed=%0d expected=%0d", Timestep, exp_ts);
                end
`ifdef SCHED_SPIKE_COUNT_EN
                vectors++;
                assert (SpikeCount === (AW+1)'(exp_sc)) else begin
                    miscompares++;
                    $error("FAIL spike_count observed=%0d expected=%0d", SpikeCount, exp_sc);
                end
`endif
            end
        end
        SpikeIn = 1'b0;
        SpikeReady = 1'b0;
    endtask

    task automatic clear_spikes();
        for (int i = 0; i < NN; i++) begin
            sp[i] = 1'b0;
            dl[i] = 0;
        end
    endtask

    initial begin
        clear_spikes();
        repeat (2) @(negedge Clock);
        check_zero("reset");
        Reset = 1'b1;

        // Plain four-neuron sweep, no spikes.
        run_sweep(4, 0, 0);

        // Neuron 1 spikes, router stalls four cycles.
        sp[1] = 1'b1;
        dl[1] = 4;
        run_sweep(3, 0, 0);
        clear_spikes();

        // Empty sweep.
        run_sweep(0, 0, 0);

        // Over-range count is clamped to NN, sparse random spikes.
        for (int i = 0; i < NN; i++) begin
            sp[i] = ($urandom_range(0, 15) == 0);
            dl[i] = $urandom_range(0, 2);
        end
        run_sweep(300, 0, 0);
        clear_spikes();

        // Reset during neuron 2 UPDATE, then a fresh sweep from address 0.
        run_sweep(5, 0, 2 * (2 + L) + 2);
        run_sweep(3, 0, 0);

        // Randomized sweeps.
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < NN; i++) begin
                sp[i] = ($urandom_range(0, 2) == 0);
                dl[i] = $urandom_range(0, 3);
            end
            run_sweep($urandom_range(1, 8), 0, 0);
        end
        clear_spikes();

        // Bring Timestep to its maximum, then a sweep with an ignored re-Start wraps it to 0.
        while (exp_ts != {TW{1'b1}}) run_sweep(0, 0, 0);
        run_sweep(3, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
